// File: rtl/entrada_digito_pkg.sv
// Shared types and constants for the digit-entry stage of the combination lock.
package entrada_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    FILTRA_PRESS,
    PRESSIONADO,
    FILTRA_SOLTA
  } estado_t;

  localparam int         DEBOUNCE_CICLOS_PADRAO = 16;
  localparam logic [3:0] BCD_MAX                = 4'd9;

  function automatic logic eh_bcd(input logic [3:0] v);
    return (v <= BCD_MAX);
  endfunction

endpackage

// File: rtl/entrada_digito_if.sv
// Button/switch inputs and accepted-digit outputs between the panel and the lock.
interface entrada_digito_if;
  logic       botao_insere;
  logic [4:1] chaves;
  logic [4:1] numero;
  logic       insere;
  logic       invalido;

  modport master (output botao_insere, chaves, input numero, insere, invalido);
  modport slave  (input botao_insere, chaves, output numero, insere, invalido);
endinterface

// File: rtl/entrada_digito_sincronizador_2ff.sv
// Width-parameterised two-flop synchroniser for asynchronous inputs.
module sincronizador_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] meta_q;
  logic [DATA_W-1:0] sinc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sinc_q <= '0;
    end else begin
      meta_q <= d_i;
      sinc_q <= meta_q;
    end
  end

  assign q_o = sinc_q;

endmodule

// File: rtl/entrada_digito.sv
// Debounced digit entry: one insere strobe per physical press, carrying the latched digit.
// Optional BCD rejection of codes above 9 is enabled with the VALIDA_BCD_EN macro.
module entrada_digito
  import entrada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int CONT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  entrada_digito_if.slave  bus
);

  localparam logic [CONT_W-1:0] CONT_FIM = CONT_W'(DEBOUNCE_CICLOS - 1);

  logic       btn_s;
  logic [3:0] chv_s;

  estado_t           estado_q, estado_d;
  logic [CONT_W-1:0] cont_q, cont_d;
  logic [3:0]        numero_q, numero_d;
  logic              insere_q, insere_d;
  logic              invalido_q, invalido_d;

  sincronizador_2ff #(.DATA_W(1)) u_sinc_botao (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.botao_insere),
    .q_o   (btn_s)
  );

  sincronizador_2ff #(.DATA_W(4)) u_sinc_chaves (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.chaves),
    .q_o   (chv_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      cont_q     <= '0;
      numero_q   <= '0;
      insere_q   <= 1'b0;
      invalido_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cont_q     <= cont_d;
      numero_q   <= numero_d;
      insere_q   <= insere_d;
      invalido_q <= invalido_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    cont_d     = cont_q;
    numero_d   = numero_q;
    insere_d   = 1'b0;
    invalido_d = 1'b0;
    unique case (estado_q)
      OCIOSO: begin
        if (btn_s) begin
          estado_d = FILTRA_PRESS;
          cont_d   = '0;
        end
      end
      FILTRA_PRESS: begin
        if (!btn_s) begin
          estado_d = OCIOSO;
          cont_d   = '0;
        end else if (cont_q == CONT_FIM) begin
          // The press is consumed here even when the code is rejected.
          estado_d = PRESSIONADO;
`ifdef VALIDA_BCD_EN
          if (eh_bcd(chv_s)) begin
            insere_d = 1'b1;
            numero_d = chv_s;
          end else begin
            invalido_d = 1'b1;
          end
`else
          insere_d = 1'b1;
          numero_d = chv_s;
`endif
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      PRESSIONADO: begin
        if (!btn_s) begin
          estado_d = FILTRA_SOLTA;
          cont_d   = '0;
        end
      end
      FILTRA_SOLTA: begin
        if (btn_s) begin
          estado_d = PRESSIONADO;
        end else if (cont_q == CONT_FIM) begin
          estado_d = OCIOSO;
        end else begin
          cont_d = cont_q + 1'b1;
        end
      end
      default: begin
        estado_d = OCIOSO;
        cont_d   = '0;
      end
    endcase
  end

  assign bus.numero   = numero_q;
  assign bus.insere   = insere_q;
  assign bus.invalido = invalido_q;

endmodule

// File: doc/entrada_digito.md
Name: entrada_digito

Overview:
Upstream input stage for the combination-lock FSM. Synchronises the raw 4-bit digit switches and the raw "insere" push-button, debounces the button, and emits exactly one single-cycle `insere` strobe per physical press. The strobe carries a stable latched digit on `numero`, which feeds the lock's `numero`/`insere` inputs directly.

Parameters:
- DEBOUNCE_CICLOS, default 16: consecutive stable synchronised cycles needed to accept a press or a release. Legal range is 2 and up; board builds override it to roughly 1e6.
- CONT_W, default 16: debounce counter width. Must satisfy 2**CONT_W > DEBOUNCE_CICLOS.

Ports:
- clk  in  1  system clock; all flops on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- botao_insere  in  1  raw, asynchronous, bouncing push-button; high = pressed.
- chaves  in  [4:1]  raw, asynchronous digit switches.
- numero  out  [4:1]  registered last accepted digit.
- insere  out  1  registered one-cycle strobe marking a new accepted digit.
- invalido  out  1  registered one-cycle strobe for a rejected code (see Optional Feature).

Behaviour:
- Reset (async, active-high) forces immediately:
  - numero = 0, insere = 0, invalido = 0;
  - all synchroniser flops = 0, counter = 0, state = OCIOSO.
- Synchronisation: botao_insere and chaves each pass through 2 flops; only the synchronised copies (btn_s, chv_s) are used below.
- FSM states: OCIOSO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA.
  - OCIOSO: if btn_s=1, go to FILTRA_PRESS with counter = 0; else stay.
  - FILTRA_PRESS:
    - if btn_s=0, go to OCIOSO and clear the counter (bounce rejected);
    - else if counter == DEBOUNCE_CICLOS-1, go to PRESSIONADO, assert insere for this one cycle, and load numero <= chv_s;
    - else increment the counter.
  - PRESSIONADO: if btn_s=0, go to FILTRA_SOLTA with counter = 0; else stay. No further strobes while held, for any duration.
  - FILTRA_SOLTA:
    - if btn_s=1, return to PRESSIONADO with no new strobe (release bounce);
    - else if counter == DEBOUNCE_CICLOS-1, go to OCIOSO;
    - else increment the counter.
- Latency: raw press is stable before edge 0; insere is high in the cycle after edge DEBOUNCE_CICLOS+2 (edge 6 for D=4).
- insere is never high for two consecutive cycles. The minimum gap between strobes is 2*DEBOUNCE_CICLOS+2 cycles.
- numero holds its value between strobes. Switch changes while the button is held, or between presses, do not affect numero.
- Counter never wraps: it is only incremented while counter < DEBOUNCE_CICLOS-1.
- Reset mid-filter or mid-hold: outputs clear at once. If the button is still held at reset release, it is treated as a fresh press and yields one strobe after the full latency.
- Unreachable state encodings return to OCIOSO on the next edge.

Optional Feature:
- Macro: VALIDA_BCD_EN.
- Defined: at the accept point, if chv_s > 9:
  - invalido pulses for one cycle;
  - insere stays 0;
  - numero is unchanged;
  - the FSM still proceeds to PRESSIONADO, so the press is consumed.
- Undefined: every code 0-15 is accepted normally and invalido is tied to 0.

Decomposition:
- Package entrada_pkg holds:
  - the state enum (OCIOSO, FILTRA_PRESS, PRESSIONADO, FILTRA_SOLTA);
  - DEBOUNCE_CICLOS_PADRAO = 16;
  - BCD_MAX = 9.
- Sub-module sincronizador_2ff: width-parameterised 2-flop synchroniser with async reset. Instantiated once for the button (width 1) and once for the switches (width 4).

Test Plan (D=4 unless stated):
1. chaves=5, clean press held 20 cycles -> exactly one insere pulse, in the cycle after edge 6; numero=5 from then on; invalido=0.
2. Bouncy press (high 2, low 1, high 2, low 1, then stable high) -> no strobe during the bounces; one strobe 4 stable cycles (plus sync) after the final rise.
3. Button held 200 cycles, chaves stepped 5->9->0 while held, then a bouncy release -> a single strobe with numero=5; no second strobe on release.
4. Sequence 5,9,0,9,8,1 entered as six separate presses -> six strobes with numero matching each digit in order, each gap ≥ 10 cycles.
5. Async reset asserted mid-FILTRA_PRESS, then the button released -> insere/numero/invalido = 0 immediately; no strobe afterwards.
6. With VALIDA_BCD_EN, chaves=12 and press -> invalido pulses once, insere stays 0, numero keeps its prior value. Without the macro -> insere pulses and numero=12.
